// File: rtl/cop_issue_ctrl_if.sv
// Core / register-file / co-processor signal bundle for the co-processor issue controller.
// master = controller side, slave = core, write-back arbiter and ISE side.
interface cop_issue_ctrl_if;
    logic        core_valid;
    logic        core_ready;
    logic [31:0] core_insn;
    logic [31:0] core_rs1;
    logic [31:0] core_rs2;
    logic        core_done;
    logic        core_illegal;
    logic        core_timeout;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wgnt;
    logic        cop_valid;
    logic [31:0] cop_insn;
    logic [31:0] cop_rs1;
    logic [31:0] cop_rs2;
    logic        cop_rdywr;
    logic        cop_ready;
    logic        cop_wait;
    logic        cop_wr;
    logic [31:0] cop_rd;

    modport master (
        input  core_valid, core_insn, core_rs1, core_rs2, rf_wgnt,
               cop_ready, cop_wait, cop_wr, cop_rd,
        output core_ready, core_done, core_illegal, core_timeout,
               rf_we, rf_waddr, rf_wdata,
               cop_valid, cop_insn, cop_rs1, cop_rs2, cop_rdywr
    );

    modport slave (
        output core_valid, core_insn, core_rs1, core_rs2, rf_wgnt,
               cop_ready, cop_wait, cop_wr, cop_rd,
        input  core_ready, core_done, core_illegal, core_timeout,
               rf_we, rf_waddr, rf_wdata,
               cop_valid, cop_insn, cop_rs1, cop_rs2, cop_rdywr
    );
endinterface

// File: rtl/cop_issue_ctrl.sv
// Issues one custom instruction to the co-processor, then retires its result via the RF port.
// Accept->done is 3 cycles with a 1-cycle ISE and immediate grant; core is stalled while busy.
module cop_issue_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              cop_clk,
    input  logic              cop_rst,
    cop_issue_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WRBK} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      insn_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic             cop_valid_q;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q;
    logic [31:0]      rf_wdata_q;
    logic             done_q;
    logic             illegal_q;
    logic             timeout_q;

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            insn_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            cop_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.core_valid) begin
                        insn_q      <= bus.core_insn;
                        rs1_q       <= bus.core_rs1;
                        rs2_q       <= bus.core_rs2;
                        cnt_q       <= '0;
                        cop_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The operand registers double as the bus drivers, so they are
                    // zeroed on every exit to keep cop_insn/rs1/rs2 at 0 when idle.
                    if (bus.cop_wait) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (TIMEOUT != 0 && cnt_q == CNT_TO) begin
                            timeout_q   <= 1'b1;
                            cop_valid_q <= 1'b0;
                            insn_q      <= '0;
                            rs1_q       <= '0;
                            rs2_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end else if (bus.cop_wr) begin
                        if (bus.cop_ready) begin
                            rf_wdata_q  <= bus.cop_rd;
                            rf_waddr_q  <= insn_q[11:7];
                            cop_valid_q <= 1'b0;
                            insn_q      <= '0;
                            rs1_q       <= '0;
                            rs2_q       <= '0;
                            if (insn_q[11:7] != 5'd0) begin
                                rf_we_q <= 1'b1;
                                state_q <= WRBK;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        illegal_q   <= 1'b1;
                        cop_valid_q <= 1'b0;
                        insn_q      <= '0;
                        rs1_q       <= '0;
                        rs2_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                WRBK: begin
                    if (bus.rf_wgnt) begin
                        rf_we_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.core_ready   = (state_q == IDLE) && !cop_rst;
    assign bus.core_done    = done_q;
    assign bus.core_illegal = illegal_q;
    assign bus.core_timeout = timeout_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.cop_valid    = cop_valid_q;
    assign bus.cop_rdywr    = cop_valid_q;
    assign bus.cop_insn     = insn_q;
    assign bus.cop_rs1      = rs1_q;
    assign bus.cop_rs2      = rs2_q;

endmodule

// File: tb/tb_cop_issue_ctrl.sv
// Randomized bench for cop_issue_ctrl: each op is a scenario (wait cycles, stalls, claim,
// grant delay) whose cycle-by-cycle outcome is predicted arithmetically from the op rules.
module tb_cop_issue_ctrl;
    localparam int TO = 8;

    logic cop_clk = 1'b0;
    logic cop_rst = 1'b1;

    cop_issue_ctrl_if bus ();

    cop_issue_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .cop_clk (cop_clk),
        .cop_rst (cop_rst),
        .bus     (bus)
    );

    always #5 cop_clk = ~cop_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pulses();
        return {bus.core_done, bus.core_illegal, bus.core_timeout};
    endfunction

    function automatic logic [31:0] mk_insn(input logic [4:0] rd);
        logic [31:0] w;
        w       = $urandom;
        w[11:7] = rd;
        w[6:0]  = 7'h0B;
        return w;
    endfunction

    task automatic drive_quiet();
        bus.core_valid = 1'b0;
        bus.core_insn  = '0;
        bus.core_rs1   = '0;
        bus.core_rs2   = '0;
        bus.rf_wgnt    = 1'b0;
        bus.cop_ready  = 1'b0;
        bus.cop_wait   = 1'b0;
        bus.cop_wr     = 1'b0;
        bus.cop_rd     = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where the outcome pulse shows.
    task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                          input int nwait, input int nstall, input bit claim,
                          input logic [31:0] rd, input int gdelay);
        int n_issue;
        bit to_ev;
        bit wb;
        to_ev   = (nwait >= TO);
        n_issue = to_ev ? TO : nwait + (claim ? nstall : 0) + 1;
        wb      = !to_ev && claim && (insn[11:7] != 5'd0);

        check("idle_ready", bus.core_ready, 1);
        bus.core_valid = 1'b1;
        bus.core_insn  = insn;
        bus.core_rs1   = rs1;
        bus.core_rs2   = rs2;
        bus.cop_wait   = 1'b0;
        bus.cop_wr     = 1'b0;
        bus.cop_ready  = 1'b0;
        @(negedge cop_clk);

        for (int i = 0; i < n_issue; i++) begin
            check("issue_ctl", {bus.cop_valid, bus.cop_rdywr, bus.core_ready, bus.rf_we, pulses()},
                  7'b1100000);
            check("issue_insn", bus.cop_insn, insn);
            check("issue_ops", {bus.cop_rs1, bus.cop_rs2}, {rs1, rs2});
            bus.core_valid = 1'($urandom_range(0, 1));
            bus.core_insn  = $urandom;
            bus.core_rs1   = $urandom;
            bus.rf_wgnt    = 1'($urandom_range(0, 1));
            bus.cop_rd     = $urandom;
            if (i < nwait) begin
                bus.cop_wait  = 1'b1;
                bus.cop_wr    = 1'($urandom_range(0, 1));
                bus.cop_ready = 1'($urandom_range(0, 1));
            end else if (i < n_issue - 1) begin
                bus.cop_wait  = 1'b0;
                bus.cop_wr    = 1'b1;
                bus.cop_ready = 1'b0;
            end else begin
                bus.cop_wait  = 1'b0;
                bus.cop_wr    = claim;
                bus.cop_ready = 1'b1;
                bus.cop_rd    = rd;
            end
            if (i == n_issue - 1 && !wb) bus.core_valid = 1'b0;
            @(negedge cop_clk);
        end

        if (to_ev) begin
            check("timeout_pulse", pulses(), 3'b001);
        end else if (!claim) begin
            check("illegal_pulse", pulses(), 3'b010);
        end else if (!wb) begin
            check("rd0_done_pulse", pulses(), 3'b100);
            check("rd0_wdata", bus.rf_wdata, rd);
        end
        if (!wb) begin
            check("end_ctl", {bus.cop_valid, bus.rf_we, bus.core_ready}, 3'b001);
            check("end_insn", bus.cop_insn, 0);
        end else begin
            for (int g = 0; g <= gdelay; g++) begin
                check("wb_ctl", {bus.rf_we, bus.cop_valid, bus.core_ready, pulses()}, 6'b100000);
                check("wb_addr", bus.rf_waddr, insn[11:7]);
                check("wb_data", bus.rf_wdata, rd);
                bus.rf_wgnt    = (g == gdelay);
                bus.core_valid = (g == gdelay) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.core_insn  = $urandom;
                bus.cop_wait   = 1'($urandom_range(0, 1));
                bus.cop_wr     = 1'($urandom_range(0, 1));
                bus.cop_rd     = $urandom;
                @(negedge cop_clk);
            end
            check("wb_done_pulse", pulses(), 3'b100);
            check("wb_end_ctl", {bus.rf_we, bus.cop_valid, bus.core_ready}, 3'b001);
        end
        bus.rf_wgnt = 1'b0;
    endtask

    task automatic reset_mid(input bit in_wrbk);
        check("rst_pre_ready", bus.core_ready, 1);
        bus.core_valid = 1'b1;
        bus.core_insn  = mk_insn(5'd3);
        bus.core_rs1   = $urandom;
        bus.core_rs2   = $urandom;
        @(negedge cop_clk);
        bus.core_valid = 1'b0;
        bus.cop_wait   = !in_wrbk;
        bus.cop_wr     = 1'b1;
        bus.cop_ready  = 1'b1;
        bus.cop_rd     = $urandom;
        bus.rf_wgnt    = 1'b0;
        if (in_wrbk) begin
            @(negedge cop_clk);
            check("rst_pre_wb", {bus.rf_we, bus.cop_valid}, 2'b10);
        end
        cop_rst = 1'b1;
        @(negedge cop_clk);
        check("rst_mid_ctl", {bus.cop_valid, bus.rf_we, bus.core_ready, pulses()}, 6'b0);
        check("rst_mid_insn", bus.cop_insn, 0);
        cop_rst = 1'b0;
        drive_quiet();
        @(negedge cop_clk);
        check("rst_after", {bus.core_ready, bus.rf_we, pulses()}, 5'b10000);
    endtask

    initial begin
        int nwait, nstall, r;
        bit claim;
        logic [4:0] rdst;
        logic [31:0] rdata;

        drive_quiet();
        cop_rst = 1'b1;
        repeat (3) @(negedge cop_clk);
        check("reset_ready", bus.core_ready, 0);
        check("reset_ctl", {bus.cop_valid, bus.cop_rdywr, bus.rf_we, pulses()}, 6'b0);
        check("reset_bus", {bus.cop_insn, bus.rf_wdata}, 64'h0);
        check("reset_waddr", bus.rf_waddr, 0);
        cop_rst = 1'b0;
        @(negedge cop_clk);

        run_op(mk_insn(5'd5), $urandom, $urandom, 0, 0, 1'b1, 32'hDEADBEEF, 0);
        run_op(mk_insn(5'd9), $urandom, $urandom, 0, 0, 1'b0, $urandom, 0);
        run_op(mk_insn(5'd7), $urandom, $urandom, 3, 0, 1'b1, 32'h12345678, 0);
        run_op(mk_insn(5'd4), $urandom, $urandom, TO + 2, 0, 1'b1, $urandom, 0);
        run_op(mk_insn(5'd6), $urandom, $urandom, TO - 1, 0, 1'b1, $urandom, 0);
        run_op(mk_insn(5'd0), $urandom, $urandom, 0, 0, 1'b1, $urandom, 0);
        run_op(mk_insn(5'd12), $urandom, $urandom, 0, 0, 1'b1, $urandom, 5);
        run_op(mk_insn(5'd2), $urandom, $urandom, 1, 3, 1'b1, $urandom, 1);
        reset_mid(1'b0);
        run_op(mk_insn(5'd8), $urandom, $urandom, 0, 0, 1'b1, $urandom, 0);
        reset_mid(1'b1);
        run_op(mk_insn(5'd31), $urandom, $urandom, 2, 1, 1'b1, $urandom, 2);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      nwait = $urandom_range(0, 2);
            else if (r < 8) nwait = $urandom_range(TO - 2, TO + 1);
            else            nwait = $urandom_range(3, 6);
            nstall = $urandom_range(0, 2);
            claim  = ($urandom_range(0, 4) != 0);
            rdst   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdata  = $urandom;
            run_op(mk_insn(rdst), $urandom, $urandom, nwait, nstall, claim, rdata,
                   $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge cop_clk);
                check("idle_gap", {bus.core_ready, bus.cop_valid, bus.rf_we, pulses()}, 6'b100000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
